if_id_pipe_reg: RTL and testbench
=================================

// Module: if_id_pipe_reg
// PURPOSE
//  Parametrised IF->ID pipeline register with valid/ready handshake and a 1-entry skid buffer.
//  Supports downstream stall, synchronous flush (branch/jump redirect), full throughput, 1-cycle latency.
//  Sits between instruction fetch and decode; replaces the plain always-load IF/ID register.
// PARAMETERS
//  pc_width     10      width of PC carried with the instruction
//  instr_width  16      instruction word width
//  nop_instr    16'h0   instruction driven on instr_id after reset/flush (instr_width bits)
//  cnt_width    16      perf counter width (used only with PERF_CNT_EN)
// PORTS
//  clk          in   1            rising-edge clock
//  rst          in   1            synchronous, active-high reset
//  flush        in   1            synchronous discard of all held and incoming entries
//  pc_if        in   pc_width     PC of the fetched instruction
//  instr_if     in   instr_width  fetched instruction
//  valid_if     in   1            fetch presents an entry
//  ready_if     out  1            register can accept; transfer when valid_if & ready_if
//  pc_id        out  pc_width     PC to decode
//  instr_id     out  instr_width  instruction to decode
//  valid_id     out  1            output entry valid
//  ready_id     in   1            decode accepts; transfer when valid_id & ready_id
//  stall_cnt    out  cnt_width    [PERF_CNT_EN only] cycles with valid_id & ~ready_id
//  bubble_cnt   out  cnt_width    [PERF_CNT_EN only] cycles with ~valid_id
// BEHAVIOUR
//  - Storage: main reg (drives *_id) + skid reg; state EMPTY / FULL / SKID (2-bit, registered).
//  - ready_if = (state != SKID); decoded from registered state only, no comb path from ready_id.
//  - EMPTY: valid_if -> load main, go FULL; else stay.
//  - FULL:  valid_if & ready_id  -> main <= input, stay FULL (back-to-back, 1 entry/cycle)
//           valid_if & ~ready_id -> skid <= input, go SKID
//           ~valid_if & ready_id -> go EMPTY (main data held, valid_id=0)
//           neither              -> hold
//  - SKID:  ready_id -> main <= skid, go FULL; else hold; input ignored (ready_if=0).
//  - valid_id = (state != EMPTY). Latency: entry accepted in cycle N appears on *_id in N+1.
//  - Order preserved; no entry dropped or duplicated except by flush/rst.
//  - flush (priority below rst, above all else): next state EMPTY, skid discarded,
//    instr_id <= nop_instr, pc_id held; entry presented with valid_if in flush cycle discarded.
//    ready_if in flush cycle still follows current state (entry is consumed then dropped).
//  - flush with ready_id=1 in same cycle: output entry counts as transferred; still EMPTY next.
//  - rst: state EMPTY, pc_id=0, instr_id=nop_instr, valid_id=0, ready_if=1 next cycle;
//    skid contents=0. Reset mid-transfer discards everything.
//  - Data outputs stable whenever valid_id & ~ready_id (AXI-style hold rule).
// CONFIGURATION
//  - PERF_CNT_EN defined: stall_cnt, bubble_cnt ports and counters exist; both reset to 0 on rst,
//    saturate at all-ones (no wrap), NOT cleared by flush; flush cycle itself counted normally.
//  - PERF_CNT_EN undefined: counter logic and both ports absent; all other behaviour identical.
// TESTING
//  1. rst, then valid_if=1 for 4 cycles (PC 0..3), ready_id=1 -> valid_id from cycle 1, pc_id 0,1,2,3
//     on consecutive cycles, ready_if=1 throughout.
//  2. FULL holding PC 5, ready_id=0, push PC 6 -> ready_if=0 next cycle, pc_id stays 5;
//     ready_id=1 -> pc_id=6 next cycle, ready_if=1.
//  3. SKID state (5 held, 6 in skid), assert flush -> next cycle valid_id=0, instr_id=nop_instr,
//     ready_if=1; release ready_id -> PC 6 never appears.
//  4. valid_if=1 with PC 9 in same cycle as flush -> valid_id=0 next cycle, PC 9 never output.
//  5. rst asserted while in SKID -> next cycle valid_id=0, pc_id=0, instr_id=nop_instr, ready_if=1.
//  6. PERF_CNT_EN, cnt_width=4: hold valid_id=1, ready_id=0 for 20 cycles -> stall_cnt=4'hF
//     (saturated); rst -> stall_cnt=0, bubble_cnt=0.

Source files
------------

// File: rtl/if_id_pipe_reg.sv
// IF->ID pipeline register with valid/ready handshake and a one-entry skid buffer.
// Entries move fetch->decode with one cycle of latency and full throughput; the skid
// register absorbs the single entry that arrives while decode stalls, so ready_if is a
// pure function of registered state.
// Optional feature macro: PERF_CNT_EN adds saturating stall/bubble counters and the
// stall_cnt / bubble_cnt ports.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// a producer holding valid high keeps its data stable until that transfer.
module if_id_pipe_reg #(
    parameter int                     pc_width    = 10,
    parameter int                     instr_width = 16,
    parameter logic [instr_width-1:0] nop_instr   = {instr_width{1'b0}},
    parameter int                     cnt_width   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [pc_width-1:0]    pc_if,
    input  logic [instr_width-1:0] instr_if,
    input  logic                   valid_if,
    output logic                   ready_if,
    output logic [pc_width-1:0]    pc_id,
    output logic [instr_width-1:0] instr_id,
    output logic                   valid_id,
    input  logic                   ready_id
`ifdef PERF_CNT_EN
    ,
    output logic [cnt_width-1:0]   stall_cnt,
    output logic [cnt_width-1:0]   bubble_cnt
`endif
);

    // EMPTY: nothing valid; FULL: main holds the output entry; SKID: main and skid both hold
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    // Counter width must be usable even when the counters are compiled out
    if (cnt_width < 1) begin : g_bad_cnt_width
        $error("cnt_width must be at least 1");
    end

    state_t                 state_q, state_d;
    logic [pc_width-1:0]    main_pc_q, main_pc_d;
    logic [instr_width-1:0] main_instr_q, main_instr_d;
    logic [pc_width-1:0]    skid_pc_q, skid_pc_d;
    logic [instr_width-1:0] skid_instr_q, skid_instr_d;

    // Handshake outputs come only from registered state, so ready_id never reaches ready_if
    assign ready_if = (state_q != SKID);
    assign valid_id = (state_q != EMPTY);
    assign pc_id    = main_pc_q;
    assign instr_id = main_instr_q;

    // Next-state and datapath loads; flush empties the pipe but keeps the last PC visible
    always_comb begin
        state_d      = state_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        if (flush) begin
            state_d      = EMPTY;
            main_instr_d = nop_instr;
            skid_pc_d    = {pc_width{1'b0}};
            skid_instr_d = {instr_width{1'b0}};
        end else begin
            case (state_q)
                EMPTY: begin
                    if (valid_if) begin
                        main_pc_d    = pc_if;
                        main_instr_d = instr_if;
                        state_d      = FULL;
                    end
                end
                FULL: begin
                    if (valid_if && ready_id) begin
                        main_pc_d    = pc_if;
                        main_instr_d = instr_if;
                    end else if (valid_if) begin
                        skid_pc_d    = pc_if;
                        skid_instr_d = instr_if;
                        state_d      = SKID;
                    end else if (ready_id) begin
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    if (ready_id) begin
                        main_pc_d    = skid_pc_q;
                        main_instr_d = skid_instr_q;
                        state_d      = FULL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State and data registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            main_pc_q    <= {pc_width{1'b0}};
            main_instr_q <= nop_instr;
            skid_pc_q    <= {pc_width{1'b0}};
            skid_instr_q <= {instr_width{1'b0}};
        end else begin
            state_q      <= state_d;
            main_pc_q    <= main_pc_d;
            main_instr_q <= main_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

`ifdef PERF_CNT_EN
    localparam logic [cnt_width-1:0] cnt_one = {{(cnt_width-1){1'b0}}, 1'b1};

    logic [cnt_width-1:0] stall_cnt_q, stall_cnt_d;
    logic [cnt_width-1:0] bubble_cnt_q, bubble_cnt_d;

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

    // Saturating counts of stalled and empty output cycles; flush does not clear them
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (valid_id && !ready_id && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + cnt_one;
        end
        if (!valid_id && !(&bubble_cnt_q)) begin
            bubble_cnt_d = bubble_cnt_q + cnt_one;
        end
    end

    // Counter registers, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= {cnt_width{1'b0}};
            bubble_cnt_q <= {cnt_width{1'b0}};
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Bench for if_id_pipe_reg: directed vector table, hand sequences, then random traffic
// checked against a queue-based model of the pipe (at most two entries in flight).
module tb_if_id_pipe_reg;

    localparam int PW = 10;
    localparam int IW = 16;
    localparam int CW = 4;
    localparam logic [IW-1:0] NOP = 16'hA5A5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, flush, valid_if, ready_id;
    logic [PW-1:0] pc_if;
    logic [IW-1:0] instr_if;
    logic          ready_if, valid_id;
    logic [PW-1:0] pc_id;
    logic [IW-1:0] instr_id;
`ifdef PERF_CNT_EN
    logic [CW-1:0] stall_cnt, bubble_cnt;
`endif

    if_id_pipe_reg #(
        .pc_width(PW), .instr_width(IW), .nop_instr(NOP), .cnt_width(CW)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .pc_if(pc_if), .instr_if(instr_if), .valid_if(valid_if), .ready_if(ready_if),
        .pc_id(pc_id), .instr_id(instr_id), .valid_id(valid_id), .ready_id(ready_id)
`ifdef PERF_CNT_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [IW-1:0] ins(input logic [PW-1:0] p);
        ins = 16'h1000 | {6'd0, p} ^ 16'h0300;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [PW-1:0] pc;
        logic [IW-1:0] instr;
    } ent_t;

    ent_t          m_q[$];
    logic [PW-1:0] m_last_pc    = '0;
    logic [IW-1:0] m_last_instr = NOP;
    int            m_stall      = 0;
    int            m_bubble     = 0;
    localparam int CNT_MAX      = (1 << CW) - 1;

    function automatic logic [PW-1:0] m_pc();
        return (m_q.size() > 0) ? m_q[0].pc : m_last_pc;
    endfunction
    function automatic logic [IW-1:0] m_instr();
        return (m_q.size() > 0) ? m_q[0].instr : m_last_instr;
    endfunction

    // One clock of the model, using the inputs currently driven
    task automatic model_step();
        ent_t e;
        bit   out_valid, in_ready;
        out_valid = (m_q.size() > 0);
        in_ready  = (m_q.size() < 2);
        if (rst) begin
            m_q.delete();
            m_last_pc = '0; m_last_instr = NOP; m_stall = 0; m_bubble = 0;
        end else begin
            if (out_valid && !ready_id && m_stall < CNT_MAX) m_stall++;
            if (!out_valid && m_bubble < CNT_MAX) m_bubble++;
            if (flush) begin
                m_last_pc = m_pc(); m_last_instr = NOP; m_q.delete();
            end else begin
                if (out_valid && ready_id) begin
                    e = m_q.pop_front();
                    m_last_pc = e.pc; m_last_instr = e.instr;
                end
                if (valid_if && in_ready) begin
                    e.pc = pc_if; e.instr = instr_if;
                    m_q.push_back(e);
                end
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic r, input logic f, input logic v, input logic rd,
                         input logic [PW-1:0] p);
        @(negedge clk);
        rst = r; flush = f; valid_if = v; ready_id = rd; pc_if = p; instr_if = ins(p);
        model_step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          r, f, v, rd;
        logic [PW-1:0] pc;
        logic          ev, er;
        logic [PW-1:0] epc;
        logic          enop;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic f, input logic v, input logic rd,
                       input int pc, input logic ev, input logic er, input int epc,
                       input logic enop);
        vec_t t;
        t.r = r; t.f = f; t.v = v; t.rd = rd; t.pc = PW'(pc);
        t.ev = ev; t.er = er; t.epc = PW'(epc); t.enop = enop;
        tbl.push_back(t);
    endtask

    initial begin
        logic [IW-1:0] exp_instr;
        rst = 1'b1; flush = 1'b0; valid_if = 1'b0; ready_id = 1'b0; pc_if = '0; instr_if = '0;

        //   rst f v rd pc    ev er epc nop
        add(1, 0, 0, 0, 0,   0, 1, 0,  1);  // reset state
        add(0, 0, 1, 1, 0,   1, 1, 0,  0);  // stream PC 0..3
        add(0, 0, 1, 1, 1,   1, 1, 1,  0);
        add(0, 0, 1, 1, 2,   1, 1, 2,  0);
        add(0, 0, 1, 1, 3,   1, 1, 3,  0);
        add(0, 0, 0, 1, 0,   0, 1, 3,  0);  // drain: data held, valid drops
        add(0, 0, 1, 0, 5,   1, 1, 5,  0);  // FULL holding 5
        add(0, 0, 1, 0, 6,   1, 0, 5,  0);  // 6 into skid
        add(0, 0, 1, 0, 7,   1, 0, 5,  0);  // 7 ignored while SKID
        add(0, 0, 0, 1, 0,   1, 1, 6,  0);  // skid moves to main
        add(0, 0, 0, 1, 0,   0, 1, 6,  0);
        add(0, 0, 1, 0, 5,   1, 1, 5,  0);
        add(0, 0, 1, 0, 6,   1, 0, 5,  0);  // SKID again
        add(0, 1, 0, 0, 0,   0, 1, 5,  1);  // flush from SKID
        add(0, 0, 0, 1, 0,   0, 1, 5,  1);  // 6 never appears
        add(0, 0, 0, 1, 0,   0, 1, 5,  1);
        add(0, 0, 1, 0, 8,   1, 1, 8,  0);
        add(0, 1, 1, 1, 9,   0, 1, 8,  1);  // PC 9 offered during flush
        add(0, 0, 0, 1, 0,   0, 1, 8,  1);
        add(0, 0, 1, 0, 10,  1, 1, 10, 0);
        add(0, 0, 1, 0, 11,  1, 0, 10, 0);  // SKID
        add(0, 0, 1, 1, 12,  0, 1, 0,  1);  // reset row, rst bit set just after the table
        add(0, 0, 1, 1, 13,  1, 1, 13, 0);
        tbl[21].r = 1'b1;                   // reset while in SKID

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].r, tbl[i].f, tbl[i].v, tbl[i].rd, tbl[i].pc);
            exp_instr = tbl[i].enop ? NOP : ins(tbl[i].epc);
            chk($sformatf("vec%0d valid_id", i), 32'(valid_id), 32'(tbl[i].ev));
            chk($sformatf("vec%0d ready_if", i), 32'(ready_if), 32'(tbl[i].er));
            chk($sformatf("vec%0d pc_id", i),    32'(pc_id),    32'(tbl[i].epc));
            chk($sformatf("vec%0d instr_id", i), 32'(instr_id), 32'(exp_instr));
        end

`ifdef PERF_CNT_EN
        // Stall counter saturation, then reset clears both counters
        drive(1, 0, 0, 0, 0);
        chk("perf rst stall", 32'(stall_cnt), 32'd0);
        chk("perf rst bubble", 32'(bubble_cnt), 32'd0);
        drive(0, 0, 1, 0, 20);
        for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0);
        chk("perf stall sat", 32'(stall_cnt), 32'hF);
        chk("perf bubble one", 32'(bubble_cnt), 32'd1);
        drive(1, 0, 0, 0, 0);
        chk("perf rst2 stall", 32'(stall_cnt), 32'd0);
        chk("perf rst2 bubble", 32'(bubble_cnt), 32'd0);
`endif

        // Random traffic against the model
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
                  PW'($urandom_range(0, (1 << PW) - 1)));
            chk("rnd valid_id", 32'(valid_id), 32'(m_q.size() > 0));
            chk("rnd ready_if", 32'(ready_if), 32'(m_q.size() < 2));
            chk("rnd pc_id",    32'(pc_id),    32'(m_pc()));
            chk("rnd instr_id", 32'(instr_id), 32'(m_instr()));
`ifdef PERF_CNT_EN
            chk("rnd stall_cnt",  32'(stall_cnt),  32'(m_stall));
            chk("rnd bubble_cnt", 32'(bubble_cnt), 32'(m_bubble));
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
